// File: rtl/iq_flush_sequencer.sv
// Issue-queue index return sequencer: fills the free list after reset and
// returns flushed entry indices from a latched mask on a selective flush.
module iq_flush_sequencer #(
    parameter int ENTRY_NUM    = 16,
    parameter int RETURN_WIDTH = 2,
    parameter int ISSUE_WIDTH  = 2,
    localparam int L  = ISSUE_WIDTH + RETURN_WIDTH,
    localparam int IW = $clog2(ENTRY_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flushReq,
    input  logic [ENTRY_NUM-1:0] flushMask,
    input  logic              hold,
    output logic [L-1:0]      outValid,
    output logic [L*IW-1:0]   outIdx,
    output logic              busy,
    output logic              initDone
);

    localparam int INIT_CYC  = (ENTRY_NUM + L - 1) / L;
    localparam int FLUSH_CYC = (ENTRY_NUM + RETURN_WIDTH - 1) / RETURN_WIDTH;
    localparam int MAX_CYC   = (INIT_CYC > FLUSH_CYC) ? INIT_CYC : FLUSH_CYC;
    localparam int CW        = $clog2(MAX_CYC) + 1;

    typedef enum logic [1:0] {RESET_WAIT, INIT, IDLE, FLUSH} stateT;

    stateT                state, stateNext;
    logic [CW-1:0]        cursor, cursorNext;
    logic [ENTRY_NUM-1:0] pendMask, pendNext, emitted;
    logic                 initDoneNext;
    int                   idx;
    logic [IW-1:0]        bitIdx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_WAIT;
            cursor   <= '0;
            pendMask <= '0;
            initDone <= 1'b0;
        end else begin
            state    <= stateNext;
            cursor   <= cursorNext;
            pendMask <= pendNext;
            initDone <= initDoneNext;
        end
    end

    always_comb begin
        stateNext    = state;
        cursorNext   = cursor;
        pendNext     = pendMask;
        initDoneNext = initDone;
        emitted      = '0;
        outValid     = '0;
        outIdx       = '0;
        idx          = 0;
        bitIdx       = '0;
        busy         = (state != IDLE);
        case (state)
            RESET_WAIT: begin
                if (!hold) stateNext = INIT;
            end
            INIT: begin
                if (!hold) begin
                    for (int i = 0; i < L; i++) begin
                        idx = int'(cursor) * L + i;
                        if (idx < ENTRY_NUM) begin
                            outValid[i]         = 1'b1;
                            outIdx[i*IW +: IW]  = IW'(idx);
                        end
                    end
                    if (int'(cursor) == INIT_CYC - 1) begin
                        stateNext    = IDLE;
                        cursorNext   = '0;
                        initDoneNext = 1'b1;
                    end else begin
                        cursorNext = cursor + CW'(1);
                    end
                end
            end
            IDLE: begin
                if (!hold && flushReq) begin
                    stateNext  = FLUSH;
                    pendNext   = flushMask;
                    cursorNext = '0;
                end
            end
            FLUSH: begin
                if (!hold) begin
                    for (int j = 0; j < RETURN_WIDTH; j++) begin
                        idx    = int'(cursor) * RETURN_WIDTH + j;
                        bitIdx = IW'(idx);
                        if (idx < ENTRY_NUM && pendMask[bitIdx]) begin
                            outValid[j]        = 1'b1;
                            outIdx[j*IW +: IW] = bitIdx;
                            emitted[bitIdx]    = 1'b1;
                        end
                    end
                end
                // A late request merges in without rewinding; passed windows get the next pass.
                pendNext = (pendMask & ~emitted) | (flushReq ? flushMask : '0);
                if (!hold) begin
                    if (int'(cursor) == FLUSH_CYC - 1) begin
                        cursorNext = '0;
                        if (pendNext == '0) stateNext = IDLE;
                    end else begin
                        cursorNext = cursor + CW'(1);
                    end
                end
            end
            default: stateNext = RESET_WAIT;
        endcase
    end

endmodule

// File: doc/iq_flush_sequencer.md
Name: iq_flush_sequencer

Overview:
Controller that owns the issue-queue entry-index return path to the issue-queue free list.
- After reset: pushes every entry index into the free list at ISSUE_WIDTH+RETURN_WIDTH indices/cycle.
- On a selective flush: scans a latched flush mask and returns flushed indices at RETURN_WIDTH/cycle.
- Asserts busy throughout so rename/dispatch stalls.

Parameters:
ENTRY_NUM, 16, issue-queue entries (power of two)
RETURN_WIDTH, 2, free-list return ports used during flush
ISSUE_WIDTH, 2, extra free-list ports usable during init (init lanes L = ISSUE_WIDTH+RETURN_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flushReq  in  1  one-cycle pulse: start/extend selective flush
flushMask  in  ENTRY_NUM  entries to free; sampled only when flushReq=1
hold  in  1  free-list port conflict; freeze sequencer this cycle
outValid  out  L  per-lane index valid
outIdx  out  L*log2(ENTRY_NUM)  per-lane index; lane i in bits [i*IW +: IW]
busy  out  1  sequencer active; dispatch must stall
initDone  out  1  level, set after init completes

Behaviour:
- States: RESET_WAIT, INIT, IDLE, FLUSH. Registers: state, cursor (window number), pendMask[ENTRY_NUM], initDone.
- Reset (async, rst_n=0): state=RESET_WAIT, cursor=0, pendMask=0, initDone=0. Outputs during reset: outValid=0, outIdx=0, busy=1, initDone=0.
- All outputs are combinational from registered state and hold only. outIdx=0 on any lane whose outValid=0.
- RESET_WAIT: outValid=0, busy=1. Next edge -> INIT. The first valid index appears the cycle after reset release.
- INIT:
  - Lane i: outValid=1, outIdx=cursor*L+i, while that value < ENTRY_NUM.
  - Cursor increments each non-hold cycle.
  - Cycle count: INIT_CYC=ceil(ENTRY_NUM/L). Defaults: 4 cycles, indices 0..15.
  - After the last window -> IDLE, initDone<=1.
  - flushReq during INIT is ignored (mask discarded).
- IDLE: outValid=0, busy=0.
  - flushReq -> FLUSH, pendMask<=flushMask, cursor<=0.
  - flushReq with flushMask=0 still enters FLUSH for one full pass. Retirement relies on fixed latency.
- FLUSH:
  - Window k covers indices k*RETURN_WIDTH..k*RETURN_WIDTH+RETURN_WIDTH-1.
  - Lane j (j<RETURN_WIDTH): outValid=pendMask[k*RW+j], outIdx=k*RW+j. Lanes >=RETURN_WIDTH are always 0.
  - On a non-hold cycle, clear emitted bits and cursor++.
  - Pass length: FLUSH_CYC=ceil(ENTRY_NUM/RETURN_WIDTH). Default 8.
  - End of pass (last window, non-hold): if pendMask after clear ≠ 0, cursor<=0 and do a new pass; otherwise -> IDLE.
  - A flush with no later flushReq therefore takes exactly FLUSH_CYC non-hold cycles.
- flushReq during FLUSH: pendMask <= (pendMask & ~emittedThisCycle) | flushMask. The cursor is not reset.
  - Bits in windows already passed are returned in the follow-up pass.
  - No index is ever emitted twice for one set bit.
- Simultaneous flushReq and end-of-pass: the merged mask decides restart vs IDLE.
- hold=1: all outValid=0, cursor and pendMask unchanged except the flushReq merge, no state change. busy keeps its value.
- busy=1 in RESET_WAIT, INIT, FLUSH.
- Reset mid-INIT/mid-FLUSH returns to RESET_WAIT. The pending mask is lost and a full re-init follows.
- Cursor width: log2(max(INIT_CYC,FLUSH_CYC))+1. No wrap aliasing.

Test Plan:
1. Reset release, hold=0 -> 1 cycle outValid=0, then 4 cycles emitting {0,1,2,3},{4,5,6,7},{8..11},{12..15}. initDone rises after cycle 4 and busy falls with it.
2. IDLE, flushReq, flushMask=0x8421 -> 8 FLUSH cycles. Valid only: idx0 at cycle 0 lane0, idx5 at cycle 2 lane1, idx10 at cycle 5 lane0, idx15 at cycle 7 lane1. Then busy=0.
3. Scenario 2 with hold=1 on cycles 1 and 2 -> outValid=0 while held; same indices emitted; total 10 cycles.
4. flushMask=0x0003, second flushReq mask=0x0005 at pass cycle 3 -> first pass emits 0,1. Second pass emits 0 (cycle 0) and 2 (cycle 1), 16 cycles total. Index 1 is not repeated.
5. Assert rst_n=0 at INIT cycle 2 -> outValid=0 immediately, busy=1, initDone=0. After release, a full 4-cycle init restarts from index 0.
6. flushReq pulse during INIT, mask=0xFFFF -> ignored. Init emits 0..15 once, then IDLE with busy=0.
